// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// frame geometry constants and a small parity helper.
package uart_pkg;

    // Frame geometry and line idle level
    localparam int   DATA_BITS            = 8;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;

    // Receiver states; PARITY is only visited when parity checking is built in
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_state_e;

    // Even parity of a data byte: the parity bit a transmitter should send
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous serial line. The chain resets
// to the idle level so that a reset never looks like a start bit.
module uart_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw line into the bottom of the chain each cycle
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Chain registers, forced to the idle level on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_recv.sv
// UART receiver: samples 8N1 frames at mid-bit using its own baud counter,
// shifts data LSB first and reports each byte with a one-cycle valid strobe
// or a one-cycle frame_err strobe when the stop bit is low.
// Optional build macro UART_RECV_PARITY_EN adds an even-parity bit between
// the data and stop bits and a parity_err strobe output.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signal,
    output logic [DATA_BITS-1:0] character,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RECV_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    // Counter terminal values: full bit period and half bit period
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    logic sync_out;

    uart_state_e          state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] character_q, character_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q,      busy_d;
`ifdef UART_RECV_PARITY_EN
    logic                 par_bit_q,   par_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (signal),
        .sync_out (sync_out)
    );

    // Next-state logic: walk the frame bit by bit, strobes default low
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        character_d  = character_q;
        valid_d      = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;
`ifdef UART_RECV_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (sync_out != IDLE_LEVEL) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (sync_out == IDLE_LEVEL) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = sync_out;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_RECV_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef UART_RECV_PARITY_EN
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bit_d = sync_out;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    busy_d = 1'b0;
                    if (sync_out != IDLE_LEVEL) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end else begin
                        state_d = IDLE;
`ifdef UART_RECV_PARITY_EN
                        if (par_bit_q != even_parity(shift_q)) begin
                            parity_err_d = 1'b1;
                        end else begin
                            character_d = shift_q;
                            valid_d     = 1'b1;
                        end
`else
                        character_d = shift_q;
                        valid_d     = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_HIGH: begin
                cnt_d = '0;
                if (sync_out == IDLE_LEVEL) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, all returned to idle values on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            character_q  <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            character_q  <= character_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
`ifdef UART_RECV_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign character  = character_q;
    assign valid      = valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef UART_RECV_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_recv.sv
// Testbench for uart_recv. Frames are built from the line protocol (start
// bit, LSB-first data, optional even parity, stop bit) and the outcome of
// each frame is predicted from those rules alone.
module tb_uart_recv;

    localparam int CPB  = 16;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       signal = 1'b1;
    logic [7:0] character;
    logic       valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RECV_PARITY_EN
    logic       parity_err;
`endif

    int errors = 0;
    int checks = 0;

    // Observation counters maintained by the monitor
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         both_cnt = 0;
    int         dbl_cnt = 0;
    int         busy_cycles = 0;
    logic       busy_prev = 1'b0;
    logic       valid_prev = 1'b0;
    logic       busy_at_valid = 1'b1;
    logic       busy_before_valid = 1'b0;
    logic [7:0] rx_q[$];

    uart_recv #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal     (signal),
        .character  (character),
        .valid      (valid),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef UART_RECV_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: record strobes and busy activity on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cnt         = valid_cnt + 1;
                rx_q.push_back(character);
                busy_at_valid     = busy;
                busy_before_valid = busy_prev;
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
`ifdef UART_RECV_PARITY_EN
            if (parity_err) perr_cnt = perr_cnt + 1;
            if (parity_err && (valid || frame_err)) both_cnt = both_cnt + 1;
`endif
            if (valid && frame_err) both_cnt = both_cnt + 1;
            if (valid && valid_prev) dbl_cnt = dbl_cnt + 1;
            if (busy) busy_cycles = busy_cycles + 1;
            busy_prev  = busy;
            valid_prev = valid;
        end
    end

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            signal = 1'b1;
        end
    endtask

    // Drive one frame on the line, then idle_bits bit periods of idle
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_flip, input int idle_bits);
        logic bits[$];
        logic par_bit;
        par_bit = (^data) ^ par_flip;
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(data[b]);
`ifdef UART_RECV_PARITY_EN
        bits.push_back(par_bit);
`endif
        bits.push_back(stop_bit);
        for (int i = 0; i < bits.size() * CPB; i++) begin
            @(negedge clk);
            signal = bits[i / CPB];
        end
        idle_cycles(idle_bits * CPB);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_cycles(3);
        checks++;
        if (character !== 8'h00) begin errors++; $display("[TB] FAIL reset_character: got %h expected 00", character); end
        checks++;
        if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        idle_cycles(CPB);
    endtask

    task automatic test_glitch();
        int v0, f0, b0;
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            signal = 1'b0;
        end
        idle_cycles(2 * CPB);
        checks++;
        if (valid_cnt - v0 != 0) begin errors++; $display("[TB] FAIL glitch_valid: got %0d strobes expected 0", valid_cnt - v0); end
        checks++;
        if (ferr_cnt - f0 != 0) begin errors++; $display("[TB] FAIL glitch_frame_err: got %0d strobes expected 0", ferr_cnt - f0); end
        checks++;
        if (character !== 8'h00) begin errors++; $display("[TB] FAIL glitch_character: got %h expected 00", character); end
        checks++;
        if ((busy_cycles - b0) < CPB / 2 - 1 || (busy_cycles - b0) > CPB / 2 + SYNC) begin
            errors++;
            $display("[TB] FAIL glitch_busy_len: got %0d cycles expected %0d..%0d", busy_cycles - b0, CPB / 2 - 1, CPB / 2 + SYNC);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_frame_64();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        busy_at_valid = 1'b1; busy_before_valid = 1'b0;
        send_frame(8'h64, 1'b1, 1'b0, 2);
        checks++;
        if (valid_cnt - v0 != 1) begin errors++; $display("[TB] FAIL f64_valid_count: got %0d expected 1", valid_cnt - v0); end
        checks++;
        if (character !== 8'h64) begin errors++; $display("[TB] FAIL f64_character: got %h expected 64", character); end
        checks++;
        if (ferr_cnt - f0 != 0) begin errors++; $display("[TB] FAIL f64_frame_err: got %0d expected 0", ferr_cnt - f0); end
        checks++;
        if (busy_at_valid !== 1'b0 || busy_before_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL f64_busy_fall: got busy %b before, %b at valid; expected 1 then 0", busy_before_valid, busy_at_valid);
        end
    endtask

    task automatic test_frame_error();
        int v0, f0, busy_seen;
        v0 = valid_cnt; f0 = ferr_cnt; busy_seen = 0;
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            signal = 1'b0;
            if (busy) busy_seen++;
        end
        idle_cycles(2 * CPB);
        checks++;
        if (ferr_cnt - f0 != 1) begin errors++; $display("[TB] FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        checks++;
        if (valid_cnt - v0 != 0) begin errors++; $display("[TB] FAIL ferr_valid: got %0d expected 0", valid_cnt - v0); end
        checks++;
        if (character !== 8'h64) begin errors++; $display("[TB] FAIL ferr_character: got %h expected 64", character); end
        checks++;
        if (busy_seen != 0) begin errors++; $display("[TB] FAIL ferr_wait_high: got busy for %0d cycles while line low, expected 0", busy_seen); end
        send_frame(8'h5A, 1'b1, 1'b0, 2);
        checks++;
        if (character !== 8'h5A) begin errors++; $display("[TB] FAIL ferr_recover: got %h expected 5a", character); end
    endtask

    task automatic test_back_to_back();
        int v0, base;
        v0 = valid_cnt; base = rx_q.size();
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 2);
        checks++;
        if (valid_cnt - v0 != 2) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d expected 2", valid_cnt - v0);
        end else begin
            checks++;
            if (rx_q[base] !== 8'h00) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 00", rx_q[base]); end
            checks++;
            if (rx_q[base + 1] !== 8'hFF) begin errors++; $display("[TB] FAIL b2b_second: got %h expected ff", rx_q[base + 1]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        logic [9:0] bits;
        v0 = valid_cnt; f0 = ferr_cnt;
        bits = {1'b1, 8'h3C, 1'b0};
        for (int i = 0; i < 5 * CPB + CPB / 2; i++) begin
            @(negedge clk);
            signal = bits[i / CPB];
        end
        @(negedge clk);
        rst = 1'b1;
        signal = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++;
        if (character !== 8'h00) begin errors++; $display("[TB] FAIL rst_character: got %h expected 00", character); end
        idle_cycles(2 * CPB);
        checks++;
        if (valid_cnt - v0 != 0 || ferr_cnt - f0 != 0) begin
            errors++;
            $display("[TB] FAIL rst_no_strobe: got %0d valid %0d frame_err expected 0 0", valid_cnt - v0, ferr_cnt - f0);
        end
        send_frame(8'h3C, 1'b1, 1'b0, 2);
        checks++;
        if (valid_cnt - v0 != 1 || character !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL rst_recover: got %0d strobes char %h expected 1 3c", valid_cnt - v0, character);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int v0, base;
        logic [7:0] d;
        v0 = valid_cnt; base = rx_q.size();
        for (int n = 0; n < 10; n++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            send_frame(d, 1'b1, 1'b0, int'($urandom_range(0, 2)));
        end
        idle_cycles(2 * CPB);
        checks++;
        if (valid_cnt - v0 != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d expected %0d", valid_cnt - v0, exp_q.size());
        end else begin
            for (int n = 0; n < exp_q.size(); n++) begin
                checks++;
                if (rx_q[base + n] !== exp_q[n]) begin
                    errors++;
                    $display("[TB] FAIL rand_byte%0d: got %h expected %h", n, rx_q[base + n], exp_q[n]);
                end
            end
        end
    endtask

`ifdef UART_RECV_PARITY_EN
    task automatic test_parity();
        int v0, p0, f0;
        v0 = valid_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h64, 1'b1, 1'b0, 2);
        checks++;
        if (valid_cnt - v0 != 1 || character !== 8'h64 || perr_cnt - p0 != 0) begin
            errors++;
            $display("[TB] FAIL par_good: got %0d valid %0d parity_err char %h expected 1 0 64", valid_cnt - v0, perr_cnt - p0, character);
        end
        send_frame(8'h3C, 1'b1, 1'b1, 2);
        checks++;
        if (perr_cnt - p0 != 1 || valid_cnt - v0 != 1 || character !== 8'h64) begin
            errors++;
            $display("[TB] FAIL par_bad: got %0d parity_err %0d valid char %h expected 1 1 64", perr_cnt - p0, valid_cnt - v0, character);
        end
        send_frame(8'h81, 1'b0, 1'b1, 2);
        checks++;
        if (ferr_cnt - f0 != 1 || perr_cnt - p0 != 1) begin
            errors++;
            $display("[TB] FAIL par_frame_priority: got %0d frame_err %0d parity_err expected 1 1", ferr_cnt - f0, perr_cnt - p0);
        end
    endtask
`endif

    task automatic test_strobe_rules();
        checks++;
        if (both_cnt != 0) begin errors++; $display("[TB] FAIL strobe_overlap: got %0d expected 0", both_cnt); end
        checks++;
        if (dbl_cnt != 0) begin errors++; $display("[TB] FAIL valid_width: got %0d multi-cycle strobes expected 0", dbl_cnt); end
    endtask

    initial begin
        $display("[TB] uart_recv bench start, CLKS_PER_BIT=%0d SYNC_STAGES=%0d", CPB, SYNC);
        test_reset();
        test_glitch();
        test_frame_64();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
`ifdef UART_RECV_PARITY_EN
        test_parity();
`endif
        test_strobe_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
